// File: rtl/sound_event_arbiter.sv
// sound_event_arbiter: shares one tone generator between the game event pulses.
// Request pulses are latched as pending bits and granted in fixed priority
// (lose > win > scored > missed > collision). Each grant plays a short note
// sequence, with note and gap lengths counted in video frames (startOfFrame).
// Optional build macro: PREEMPT_EN lets a higher-priority pending request abort
// the event that is playing. When it is undefined, events always run to completion.
module sound_event_arbiter #(
    parameter int unsigned NOTE_FRAMES = 8,
    parameter int unsigned GAP_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       loseReq,
    input  logic       winReq,
    input  logic       scoredReq,
    input  logic       missedReq,
    input  logic       collisionReq,
    input  logic       mute,
    output logic       sound_on,
    output logic [3:0] tone_id,
    output logic [2:0] active_event,
    output logic       busy,
    output logic       done_pulse
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [7:0] NoteFrames = 8'(NOTE_FRAMES);
    localparam logic [7:0] GapFrames  = 8'(GAP_FRAMES);
    localparam bit         HasGap     = (GAP_FRAMES != 0);
    localparam logic [2:0] NoEvent    = 3'd7;

    // Note code for note idx of event ev
    function automatic logic [3:0] noteOf(input logic [2:0] ev, input logic [1:0] idx);
        logic [3:0] n;
        n = 4'd0;
        case (ev)
            3'd0: case (idx)
                2'd0:    n = 4'd7;
                2'd1:    n = 4'd5;
                2'd2:    n = 4'd3;
                default: n = 4'd1;
            endcase
            3'd1: case (idx)
                2'd0:    n = 4'd1;
                2'd1:    n = 4'd3;
                2'd2:    n = 4'd5;
                default: n = 4'd8;
            endcase
            3'd2:    n = (idx == 2'd0) ? 4'd5 : 4'd8;
            3'd3:    n = (idx == 2'd0) ? 4'd3 : 4'd2;
            3'd4:    n = 4'd10;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // Index of the final note of event ev
    function automatic logic [1:0] lastIdx(input logic [2:0] ev);
        logic [1:0] l;
        case (ev)
            3'd0, 3'd1: l = 2'd3;
            3'd2, 3'd3: l = 2'd1;
            default:    l = 2'd0;
        endcase
        return l;
    endfunction

    // Lowest set bit index (highest priority)
    function automatic logic [2:0] lowestSet(input logic [4:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    logic [1:0] stateQ, stateD;
    logic [4:0] pendingQ, pendingD;
    logic [1:0] noteIdxQ, noteIdxD;
    logic [7:0] frameCntQ, frameCntD;
    logic [3:0] toneQ, toneD;
    logic [2:0] eventQ, eventD;
    logic       soundOnQ, soundOnD;
    logic       busyQ, busyD;
    logic       doneQ, doneD;

    logic [4:0] reqVec;
    logic [4:0] clearMask;
    logic [2:0] grantIdx;
    logic [7:0] frameNext;
    logic [1:0] noteIdxNext;
    logic       preemptReq;

    assign reqVec      = {collisionReq, missedReq, scoredReq, winReq, loseReq};
    assign grantIdx    = lowestSet(pendingQ);
    assign frameNext   = frameCntQ + 8'd1;
    assign noteIdxNext = noteIdxQ + 2'd1;

`ifdef PREEMPT_EN
    logic [4:0] higherMask;

    // Pending bits that outrank the event currently playing
    always_comb begin
        higherMask = '0;
        for (int i = 0; i < 5; i++) begin
            higherMask[i] = (3'(i) < eventQ);
        end
    end

    assign preemptReq = (stateQ != IDLE) && (|(pendingQ & higherMask));
`else
    assign preemptReq = 1'b0;
`endif

    // Next-state: grant, note/gap frame counting, pending capture
    always_comb begin
        stateD    = stateQ;
        noteIdxD  = noteIdxQ;
        frameCntD = frameCntQ;
        toneD     = toneQ;
        eventD    = eventQ;
        soundOnD  = soundOnQ;
        busyD     = busyQ;
        doneD     = 1'b0;
        clearMask = '0;

        if ((stateQ == IDLE && (|pendingQ)) || preemptReq) begin
            // Grant; a preempted event is simply dropped, no done_pulse
            stateD              = PLAY;
            noteIdxD            = 2'd0;
            frameCntD           = 8'd0;
            toneD               = noteOf(grantIdx, 2'd0);
            eventD              = grantIdx;
            soundOnD            = !mute;
            busyD               = 1'b1;
            clearMask[grantIdx] = 1'b1;
        end else begin
            case (stateQ)
                IDLE: ;
                PLAY: begin
                    soundOnD = !mute;
                    if (startOfFrame) begin
                        if (frameNext == NoteFrames) begin
                            frameCntD = 8'd0;
                            if (noteIdxQ == lastIdx(eventQ)) begin
                                stateD   = IDLE;
                                doneD    = 1'b1;
                                soundOnD = 1'b0;
                                eventD   = NoEvent;
                                busyD    = 1'b0;
                            end else if (HasGap) begin
                                stateD   = GAP;
                                soundOnD = 1'b0;
                            end else begin
                                noteIdxD = noteIdxNext;
                                toneD    = noteOf(eventQ, noteIdxNext);
                            end
                        end else begin
                            frameCntD = frameNext;
                        end
                    end
                end
                GAP: begin
                    soundOnD = 1'b0;
                    if (startOfFrame) begin
                        if (frameNext == GapFrames) begin
                            stateD    = PLAY;
                            noteIdxD  = noteIdxNext;
                            toneD     = noteOf(eventQ, noteIdxNext);
                            soundOnD  = !mute;
                            frameCntD = 8'd0;
                        end else begin
                            frameCntD = frameNext;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to idle
                    stateD   = IDLE;
                    soundOnD = 1'b0;
                    eventD   = NoEvent;
                    busyD    = 1'b0;
                end
            endcase
        end

        // Pulses arriving in the grant cycle are still captured
        pendingD = (pendingQ & ~clearMask) | reqVec;
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ    <= IDLE;
            pendingQ  <= 5'b0;
            noteIdxQ  <= 2'd0;
            frameCntQ <= 8'd0;
            toneQ     <= 4'd0;
            eventQ    <= NoEvent;
            soundOnQ  <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            pendingQ  <= pendingD;
            noteIdxQ  <= noteIdxD;
            frameCntQ <= frameCntD;
            toneQ     <= toneD;
            eventQ    <= eventD;
            soundOnQ  <= soundOnD;
            busyQ     <= busyD;
            doneQ     <= doneD;
        end
    end

    assign sound_on     = soundOnQ;
    assign tone_id      = toneQ;
    assign active_event = eventQ;
    assign busy         = busyQ;
    assign done_pulse   = doneQ;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Directed bench for sound_event_arbiter with a note/done scoreboard.
// Honours PREEMPT_EN the same way as the design build.
module tb_sound_event_arbiter;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       mute = 1'b0;
    logic [4:0] reqs = 5'b0;
    logic       sound_on;
    logic [3:0] tone_id;
    logic [2:0] active_event;
    logic       busy;
    logic       done_pulse;

    int checks = 0;
    int errors = 0;
    int sofCount = 0;

    logic [6:0] expQ[$];
    logic [3:0] doneQ[$];

    int noteTab[5][4] = '{'{7, 5, 3, 1}, '{1, 3, 5, 8}, '{5, 8, 0, 0}, '{3, 2, 0, 0}, '{10, 0, 0, 0}};
    int noteCnt[5] = '{4, 4, 2, 2, 1};

    sound_event_arbiter #(
        .NOTE_FRAMES(8),
        .GAP_FRAMES(2)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .loseReq(reqs[0]),
        .winReq(reqs[1]),
        .scoredReq(reqs[2]),
        .missedReq(reqs[3]),
        .collisionReq(reqs[4]),
        .mute(mute),
        .sound_on(sound_on),
        .tone_id(tone_id),
        .active_event(active_event),
        .busy(busy),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // One startOfFrame pulse every 100 cycles
    initial begin
        forever begin
            repeat (99) @(posedge clk);
            #1 startOfFrame = 1'b1;
            sofCount++;
            @(posedge clk);
            #1 startOfFrame = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pushEvent(input int ev, input int count);
        for (int i = 0; i < count; i++) expQ.push_back({3'(ev), 4'(noteTab[ev][i])});
    endtask

    task automatic pushFull(input int ev);
        pushEvent(ev, noteCnt[ev]);
        doneQ.push_back(4'(ev));
    endtask

    task automatic pulse(input logic [4:0] m);
        @(posedge clk);
        #1 reqs = m;
        @(posedge clk);
        #1 reqs = 5'b0;
    endtask

    task automatic waitSof(input int target);
        int n;
        n = 0;
        while (sofCount < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Returns at the negedge of the done_pulse cycle
    task automatic waitDone(input string tag, output bit sawSound);
        bit got;
        got = 1'b0;
        sawSound = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (sound_on === 1'b1) sawSound = 1'b1;
            if (done_pulse === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    // Scoreboard monitor: each note start and each done_pulse pops an expectation
    logic       prevBusy = 1'b0;
    logic [3:0] prevTone = 4'd0;
    logic [2:0] prevAct = 3'd7;
    logic [6:0] eNote;
    logic [3:0] eDone;
    always @(negedge clk) begin
        if (busy === 1'b1 && (prevBusy !== 1'b1 || tone_id !== prevTone || active_event !== prevAct)) begin
            checks++;
            eNote = (expQ.size() != 0) ? expQ.pop_front() : 7'h7f;
            assert ({active_event, tone_id} === eNote) else begin
                errors++;
                $error("FAIL note observed ev %0d tone %0d expected ev %0d tone %0d",
                       active_event, tone_id, eNote[6:4], eNote[3:0]);
            end
        end
        if (done_pulse === 1'b1) begin
            checks++;
            eDone = (doneQ.size() != 0) ? doneQ.pop_front() : 4'hf;
            assert ({1'b0, prevAct} === eDone) else begin
                errors++;
                $error("FAIL done_event observed %0d expected %0d", prevAct, eDone);
            end
        end
        prevBusy = busy;
        prevTone = tone_id;
        prevAct  = active_event;
    end

    initial begin
        int base;
        bit s;
        bit sawBusy;

        // Reset values
        #2 resetN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sound_on", sound_on, 0);
        check("rst_tone_id", tone_id, 0);
        check("rst_active_event", active_event, 7);
        check("rst_busy", busy, 0);
        check("rst_done_pulse", done_pulse, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Scored: latency and note/gap timing
        pushFull(2);
        pulse(5'b00100);
        check("lat_cycle1_sound_on", sound_on, 0);
        @(posedge clk);
        #1;
        check("lat_cycle2_sound_on", sound_on, 1);
        check("lat_cycle2_tone", tone_id, 5);
        check("lat_cycle2_active", active_event, 2);
        check("lat_cycle2_busy", busy, 1);
        base = sofCount;
        waitSof(base + 8);
        check("note1_last_frame_on", sound_on, 1);
        @(negedge clk);
        check("gap_sound_off", sound_on, 0);
        check("gap_tone_hold", tone_id, 5);
        waitSof(base + 10);
        @(negedge clk);
        check("note2_tone", tone_id, 8);
        check("note2_sound_on", sound_on, 1);
        waitDone("scored_done_seen", s);
        check("scored_frames", sofCount - base, 18);
        check("scored_done_active", active_event, 7);
        check("scored_done_busy", busy, 0);
        check("scored_done_sound", sound_on, 0);
        @(negedge clk);
        check("done_one_cycle", done_pulse, 0);
        check("idle_tone_hold", tone_id, 8);

        // Simultaneous collision, missed, win
        pushFull(1);
        pushFull(3);
        pushFull(4);
        pulse(5'b11010);
        waitDone("win_done_seen", s);
        check("win_done_busy_low", busy, 0);
        @(negedge clk);
        check("after_win_busy_high", busy, 1);
        check("after_win_active", active_event, 3);
        waitDone("missed_done_seen", s);
        check("missed_done_busy_low", busy, 0);
        @(negedge clk);
        check("after_missed_busy_high", busy, 1);
        check("after_missed_active", active_event, 4);
        waitDone("collision_done_seen", s);
        repeat (5) @(negedge clk);
        check("triple_idle", busy, 0);

        // Repeated collision requests merge into one replay
        pushFull(1);
        pushFull(4);
        pulse(5'b00010);
        @(posedge clk);
        #1 base = sofCount;
        waitSof(base + 3);
        pulse(5'b10000);
        waitSof(base + 12);
        pulse(5'b10000);
        waitSof(base + 25);
        pulse(5'b10000);
        waitDone("merge_win_done_seen", s);
        waitDone("merge_collision_done_seen", s);
        sawBusy = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (busy === 1'b1) sawBusy = 1'b1;
        end
        check("merge_no_second_collision", sawBusy, 0);

        // Muted lose: silent, same tones and timing
        mute = 1'b1;
        pushFull(0);
        pulse(5'b00001);
        @(posedge clk);
        #1 base = sofCount;
        check("mute_busy", busy, 1);
        waitDone("mute_done_seen", s);
        check("mute_silent", s, 0);
        check("mute_frames", sofCount - base, 38);
        mute = 1'b0;
        repeat (3) @(negedge clk);

        // Lose requested during note 2 of win
`ifdef PREEMPT_EN
        pushEvent(1, 2);
        pushFull(0);
`else
        pushFull(1);
        pushFull(0);
`endif
        pulse(5'b00010);
        @(posedge clk);
        #1 base = sofCount;
        waitSof(base + 10);
        repeat (5) @(negedge clk);
        check("pre_note2_tone", tone_id, 3);
        pulse(5'b00001);
        @(posedge clk);
        #1;
`ifdef PREEMPT_EN
        check("preempt_tone", tone_id, 7);
        check("preempt_active", active_event, 0);
        waitDone("preempt_lose_done_seen", s);
`else
        check("nopreempt_tone", tone_id, 3);
        check("nopreempt_active", active_event, 1);
        waitDone("nopreempt_win_done_seen", s);
        waitDone("nopreempt_lose_done_seen", s);
`endif
        repeat (3) @(negedge clk);

        // Reset during GAP with scored pending
        pushEvent(2, 1);
        pulse(5'b00100);
        @(posedge clk);
        #1 base = sofCount;
        waitSof(base + 8);
        repeat (3) @(negedge clk);
        check("gapreset_in_gap_sound", sound_on, 0);
        check("gapreset_in_gap_busy", busy, 1);
        pulse(5'b00100);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("gapreset_sound_on", sound_on, 0);
        check("gapreset_tone_id", tone_id, 0);
        check("gapreset_active", active_event, 7);
        check("gapreset_busy", busy, 0);
        check("gapreset_done", done_pulse, 0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        sawBusy = 1'b0;
        repeat (350) begin
            @(negedge clk);
            if (busy === 1'b1 || sound_on === 1'b1) sawBusy = 1'b1;
        end
        check("gapreset_nothing_plays", sawBusy, 0);

        check("notes_all_seen", expQ.size(), 0);
        check("dones_all_seen", doneQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
